// File: rtl/seg7_scan_mux.sv
// Time-multiplexed common-anode 7-segment driver with a built-in scan prescaler,
// blink generator, decimal points, leading-zero suppression and dead-time blanking.
module seg7_scan_mux #(
    parameter int NUM_DIGITS  = 4,
    parameter int SCAN_DIV    = 4,
    parameter int DEAD_CYCLES = 1,
    parameter int BLINK_DIV   = 32
) (
    input  logic                    fastclk,
    input  logic                    rst_n,
    input  logic                    en,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blink_mask,
    input  logic [NUM_DIGITS-1:0]   dp_mask,
    input  logic                    lz_suppress,
    output logic [NUM_DIGITS-1:0]   anode,
    output logic [6:0]              segment,
    output logic                    dp,
    output logic                    blink_phase
);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int CNT_W   = $clog2(SCAN_DIV);
    localparam int BLINK_W = $clog2(BLINK_DIV);
    localparam logic [6:0]         SEG_BLANK = 7'h7F;
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [CNT_W-1:0]   CNT_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0]   CNT_DEAD  = CNT_W'(DEAD_CYCLES);
    localparam logic [BLINK_W-1:0] BLK_LAST  = BLINK_W'(BLINK_DIV - 1);

    logic [IDX_W-1:0]        r_idx;
    logic [CNT_W-1:0]        r_cnt;
    logic [BLINK_W-1:0]      r_blinkCnt;
    logic                    r_blinkPhase;
    logic [4*NUM_DIGITS-1:0] r_snapDigits;
    logic [NUM_DIGITS-1:0]   r_snapBlink;
    logic [NUM_DIGITS-1:0]   r_snapDp;
    logic                    r_snapLz;
    logic [NUM_DIGITS-1:0]   r_anode;
    logic [6:0]              r_segment;
    logic                    r_dp;

    logic [3:0]              w_digitVal;
    logic [NUM_DIGITS-1:0]   w_upperZero;
    logic [NUM_DIGITS-1:0]   w_anodeDrive;
    logic                    w_zeroRun;
    logic                    w_blank;

    function automatic logic [6:0] decode(input logic [3:0] v);
        case (v)
            4'h0:    return 7'b0000001;
            4'h1:    return 7'b1001111;
            4'h2:    return 7'b0010010;
            4'h3:    return 7'b0000110;
            4'h4:    return 7'b1001100;
            4'h5:    return 7'b0100100;
            4'h6:    return 7'b0100000;
            4'h7:    return 7'b0001111;
            4'h8:    return 7'b0000000;
            4'h9:    return 7'b0000100;
            4'hF:    return SEG_BLANK;
            default: return 7'b1111110;
        endcase
    endfunction

    // w_upperZero[i] is set when snapshot digits i..NUM_DIGITS-1 are all zero
    always_comb begin
        w_digitVal   = 4'd0;
        w_upperZero  = '0;
        w_anodeDrive = '1;
        w_zeroRun    = 1'b1;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            w_zeroRun      = w_zeroRun && (r_snapDigits[4*i +: 4] == 4'd0);
            w_upperZero[i] = w_zeroRun;
            if (IDX_W'(i) == r_idx) begin
                w_digitVal      = r_snapDigits[4*i +: 4];
                w_anodeDrive[i] = 1'b0;
            end
        end
        w_blank = (r_snapBlink[r_idx] && r_blinkPhase)
               || (r_snapLz && (r_idx != '0) && w_upperZero[r_idx]);
    end

    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= 1'b0;
        end else if (r_blinkCnt == BLK_LAST) begin
            r_blinkCnt   <= '0;
            r_blinkPhase <= ~r_blinkPhase;
        end else begin
            r_blinkCnt   <= r_blinkCnt + 1'b1;
        end
    end

    // Outputs are derived from the pre-edge slot position, so they trail idx/cnt by one cycle
    always_ff @(posedge fastclk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_snapDigits <= '0;
            r_snapBlink  <= '0;
            r_snapDp     <= '0;
            r_snapLz     <= 1'b0;
            r_anode      <= '1;
            r_segment    <= SEG_BLANK;
            r_dp         <= 1'b1;
        end else if (!en) begin
            r_idx        <= '0;
            r_cnt        <= '0;
            r_anode      <= '1;
            r_segment    <= SEG_BLANK;
            r_dp         <= 1'b1;
        end else begin
            if (r_cnt == '0) begin
                r_snapDigits <= digits;
                r_snapBlink  <= blink_mask;
                r_snapDp     <= dp_mask;
                r_snapLz     <= lz_suppress;
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt <= '0;
                r_idx <= (r_idx == IDX_LAST) ? '0 : r_idx + 1'b1;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_cnt < CNT_DEAD) begin
                r_anode   <= '1;
                r_segment <= SEG_BLANK;
                r_dp      <= 1'b1;
            end else begin
                r_anode   <= w_anodeDrive;
                r_segment <= w_blank ? SEG_BLANK : decode(w_digitVal);
                r_dp      <= w_blank ? 1'b1 : ~r_snapDp[r_idx];
            end
        end
    end

    assign anode       = r_anode;
    assign segment     = r_segment;
    assign dp          = r_dp;
    assign blink_phase = r_blinkPhase;

endmodule

// File: tb/tb_seg7_scan_mux.sv
// Scoreboard bench for seg7_scan_mux: stimulus queues per-cycle expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_seg7_scan_mux;
    logic        fastclk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [15:0] digits;
    logic [3:0]  blink_mask;
    logic [3:0]  dp_mask;
    logic        lz_suppress;
    logic [3:0]  anode;
    logic [6:0]  segment;
    logic        dp;
    logic        blink_phase;

    typedef struct {
        int         cyc;
        int         slot;
        int         step;
        logic [3:0] anode;
        logic [6:0] seg;
        logic       dp;
        logic       blink;
    } exp_t;

    exp_t sbQ[$];
    exp_t mon;
    int   cyc         = 0;
    int   rstRel      = 0;
    int   slotNo      = 0;
    int   totalChecks = 0;
    int   badChecks   = 0;

    seg7_scan_mux #(
        .NUM_DIGITS (4),
        .SCAN_DIV   (4),
        .DEAD_CYCLES(1),
        .BLINK_DIV  (32)
    ) dut (
        .fastclk    (fastclk),
        .rst_n      (rst_n),
        .en         (en),
        .digits     (digits),
        .blink_mask (blink_mask),
        .dp_mask    (dp_mask),
        .lz_suppress(lz_suppress),
        .anode      (anode),
        .segment    (segment),
        .dp         (dp),
        .blink_phase(blink_phase)
    );

    initial forever #5 fastclk = ~fastclk;

    always @(posedge fastclk) cyc <= cyc + 1;

    // Blink phase visible after edge n, counted from the last reset release
    function automatic logic phaseAfter(input int n);
        return (((n - rstRel) / 32) % 2) == 1;
    endfunction

    task automatic checkOutput(input exp_t e);
        totalChecks++;
        if (anode !== e.anode) begin
            badChecks++;
            $display("[TB] FAIL slot%0d.c%0d anode got=%b want=%b", e.slot, e.step, anode, e.anode);
        end
        totalChecks++;
        if (segment !== e.seg) begin
            badChecks++;
            $display("[TB] FAIL slot%0d.c%0d segment got=%b want=%b", e.slot, e.step, segment, e.seg);
        end
        totalChecks++;
        if (dp !== e.dp) begin
            badChecks++;
            $display("[TB] FAIL slot%0d.c%0d dp got=%b want=%b", e.slot, e.step, dp, e.dp);
        end
        totalChecks++;
        if (blink_phase !== e.blink) begin
            badChecks++;
            $display("[TB] FAIL slot%0d.c%0d blink_phase got=%b want=%b", e.slot, e.step, blink_phase, e.blink);
        end
    endtask

    always @(negedge fastclk) begin
        while (sbQ.size() > 0 && sbQ[0].cyc <= cyc) begin
            mon = sbQ.pop_front();
            checkOutput(mon);
        end
    end

    task automatic pushEntry(input int n, input logic [3:0] a, input logic [6:0] s,
                             input logic d, input logic b, input int step);
        exp_t e;
        e.cyc   = n;
        e.slot  = slotNo;
        e.step  = step;
        e.anode = a;
        e.seg   = s;
        e.dp    = d;
        e.blink = b;
        sbQ.push_back(e);
    endtask

    task automatic pushSlot(input int idx, input logic [6:0] seg, input logic dpv, input logic blinkable);
        logic [3:0] drv;
        int         n;
        slotNo++;
        drv      = 4'hF;
        drv[idx] = 1'b0;
        pushEntry(cyc + 1, 4'hF, 7'h7F, 1'b1, phaseAfter(cyc + 1), 0);
        for (int c = 1; c < 4; c++) begin
            n = cyc + 1 + c;
            if (blinkable && phaseAfter(n - 1))
                pushEntry(n, drv, 7'h7F, 1'b1, phaseAfter(n), c);
            else
                pushEntry(n, drv, seg, dpv, phaseAfter(n), c);
        end
    endtask

    task automatic pushIdle(input int count, input logic inReset);
        slotNo++;
        for (int c = 0; c < count; c++)
            pushEntry(cyc + 1 + c, 4'hF, 7'h7F, 1'b1, inReset ? 1'b0 : phaseAfter(cyc + 1 + c), c);
    endtask

    task automatic waitEdges(input int k);
        repeat (k) @(posedge fastclk);
        #1;
    endtask

    task automatic applyStimulus(input logic [15:0] d, input logic [3:0] bm,
                                 input logic [3:0] dpm, input logic lz);
        digits      = d;
        blink_mask  = bm;
        dp_mask     = dpm;
        lz_suppress = lz;
    endtask

    task automatic runVec(input logic [15:0] d, input logic [3:0] bm, input logic [3:0] dpm,
                          input logic lz, input int idx, input logic [6:0] seg, input logic dpv);
        applyStimulus(d, bm, dpm, lz);
        pushSlot(idx, seg, dpv, bm[idx]);
        waitEdges(4);
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b1;
        applyStimulus(16'h1234, 4'b0000, 4'b0000, 1'b0);
        pushIdle(3, 1'b1);
        waitEdges(3);
        rst_n  = 1'b1;
        rstRel = cyc;

        runVec(16'h1234, 4'b0000, 4'b0000, 1'b0, 0, 7'b1001100, 1'b1);
        runVec(16'h1234, 4'b0000, 4'b0000, 1'b0, 1, 7'b0000110, 1'b1);
        runVec(16'h1234, 4'b0000, 4'b0000, 1'b0, 2, 7'b0010010, 1'b1);
        runVec(16'h1234, 4'b0000, 4'b0000, 1'b0, 3, 7'b1001111, 1'b1);
        runVec(16'h1234, 4'b0000, 4'b0000, 1'b0, 0, 7'b1001100, 1'b1);

        runVec(16'h0005, 4'b0000, 4'b0000, 1'b1, 1, 7'h7F,      1'b1);
        runVec(16'h0005, 4'b0000, 4'b0000, 1'b1, 2, 7'h7F,      1'b1);
        runVec(16'h0005, 4'b0000, 4'b0000, 1'b1, 3, 7'h7F,      1'b1);
        runVec(16'h0005, 4'b0000, 4'b0000, 1'b1, 0, 7'b0100100, 1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b1, 1, 7'h7F,      1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b1, 2, 7'h7F,      1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b1, 3, 7'h7F,      1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b1, 0, 7'b0000001, 1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b0, 1, 7'b0000001, 1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b0, 2, 7'b0000001, 1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b0, 3, 7'b0000001, 1'b1);
        runVec(16'h0000, 4'b0000, 4'b0000, 1'b0, 0, 7'b0000001, 1'b1);
        runVec(16'h0105, 4'b0000, 4'b0000, 1'b1, 1, 7'b0000001, 1'b1);
        runVec(16'h0105, 4'b0000, 4'b0000, 1'b1, 2, 7'b1001111, 1'b1);
        runVec(16'h0105, 4'b0000, 4'b0000, 1'b1, 3, 7'h7F,      1'b1);
        runVec(16'h0105, 4'b0000, 4'b0000, 1'b1, 0, 7'b0100100, 1'b1);

        runVec(16'hFA00, 4'b0000, 4'b0010, 1'b0, 1, 7'b0000001, 1'b0);
        runVec(16'hFA00, 4'b0000, 4'b0010, 1'b0, 2, 7'b1111110, 1'b1);
        runVec(16'hFA00, 4'b0000, 4'b0010, 1'b0, 3, 7'h7F,      1'b1);
        runVec(16'hFA00, 4'b0000, 4'b0010, 1'b0, 0, 7'b0000001, 1'b1);
        runVec(16'h6789, 4'b0000, 4'b1111, 1'b0, 1, 7'b0000000, 1'b0);
        runVec(16'h6789, 4'b0000, 4'b1111, 1'b0, 2, 7'b0001111, 1'b0);
        runVec(16'h6789, 4'b0000, 4'b1111, 1'b0, 3, 7'b0100000, 1'b0);
        runVec(16'h6789, 4'b0000, 4'b1111, 1'b0, 0, 7'b0000100, 1'b0);
        runVec(16'hCBDE, 4'b0000, 4'b0000, 1'b0, 1, 7'b1111110, 1'b1);
        runVec(16'hCBDE, 4'b0000, 4'b0000, 1'b0, 2, 7'b1111110, 1'b1);
        runVec(16'hCBDE, 4'b0000, 4'b0000, 1'b0, 3, 7'b1111110, 1'b1);
        runVec(16'hCBDE, 4'b0000, 4'b0000, 1'b0, 0, 7'b1111110, 1'b1);

        // Sixteen slots span both blink phases
        for (int r = 0; r < 4; r++) begin
            runVec(16'h1259, 4'b1100, 4'b0000, 1'b0, 1, 7'b0100100, 1'b1);
            runVec(16'h1259, 4'b1100, 4'b0000, 1'b0, 2, 7'b0010010, 1'b1);
            runVec(16'h1259, 4'b1100, 4'b0000, 1'b0, 3, 7'b1001111, 1'b1);
            runVec(16'h1259, 4'b1100, 4'b0000, 1'b0, 0, 7'b0000100, 1'b1);
        end

        runVec(16'h1111, 4'b0000, 4'b0000, 1'b0, 1, 7'b1001111, 1'b1);
        runVec(16'h1111, 4'b0000, 4'b0000, 1'b0, 2, 7'b1001111, 1'b1);
        runVec(16'h1111, 4'b0000, 4'b0000, 1'b0, 3, 7'b1001111, 1'b1);
        applyStimulus(16'h1111, 4'b0000, 4'b0000, 1'b0);
        pushSlot(0, 7'b1001111, 1'b1, 1'b0);
        waitEdges(2);
        applyStimulus(16'h2222, 4'b0000, 4'b0000, 1'b0);
        waitEdges(2);
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 1, 7'b0010010, 1'b1);
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 2, 7'b0010010, 1'b1);
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 3, 7'b0010010, 1'b1);

        // Reset lands between edges while digit 0 is being driven
        slotNo++;
        pushEntry(cyc + 1, 4'hF, 7'h7F, 1'b1, phaseAfter(cyc + 1), 0);
        pushEntry(cyc + 2, 4'hF, 7'h7F, 1'b1, 1'b0, 1);
        waitEdges(2);
        rst_n = 1'b0;
        pushIdle(2, 1'b1);
        waitEdges(2);
        rst_n  = 1'b1;
        rstRel = cyc;
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 0, 7'b0010010, 1'b1);
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 1, 7'b0010010, 1'b1);

        slotNo++;
        pushEntry(cyc + 1, 4'hF,    7'h7F,      1'b1, phaseAfter(cyc + 1), 0);
        pushEntry(cyc + 2, 4'b1011, 7'b0010010, 1'b1, phaseAfter(cyc + 2), 1);
        waitEdges(2);
        en = 1'b0;
        pushIdle(10, 1'b0);
        waitEdges(10);
        en = 1'b1;
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 0, 7'b0010010, 1'b1);
        runVec(16'h2222, 4'b0000, 4'b0000, 1'b0, 1, 7'b0010010, 1'b1);

        waitEdges(2);
        totalChecks++;
        if (sbQ.size() != 0) begin
            badChecks++;
            $display("[TB] FAIL drain pending got=%0d want=0", sbQ.size());
        end
        $display("test done: total=%0d bad=%0d", totalChecks, badChecks);
        $finish;
    end

endmodule
